rv_stream_source: RTL and testbench
===================================

# rv_stream_source

Transmitter end of the 8-bit ready/valid stream carried through our proxy chain. On a start command it emits a packet of `len` beats with data `seed + i` on the downstream ready/valid port. It honours the valid-hold rules, inserts an optional programmable idle gap after each accepted beat, and reports completion. It sits upstream of the ready/valid proxies as the stimulus and traffic source for link bring-up and throughput measurement.

## Interface
- `DATA_W`, default 8: data width. The pattern arithmetic is modulo 2^DATA_W.
- `LEN_W`, default 8: width of the length field and of the beat counter.
- `GAP_W`, default 4: width of the gap field.

- `clk` input 1: the single clock; all logic on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: command strobe; sampled only while `busy`=0.
- `len` input LEN_W: number of beats in the packet; 0 means an empty packet.
- `seed` input DATA_W: data value of beat 0.
- `gap` input GAP_W: number of idle cycles with valid low after each non-final accepted beat.
- `down_data` output DATA_W: beat data.
- `down_valid` output 1: beat valid.
- `down_ready` input 1: sink ready.
- `busy` output 1: a packet is in progress.
- `done` output 1: one-cycle pulse marking packet completion.
- `beat_cnt` output LEN_W: number of beats accepted in the current or last packet.

## Operation
- `len`, `seed` and `gap` are latched on accepted `start`. Later changes to them have no effect on the running packet.
- State machine with four states:
  - IDLE: `start`=1 with `len`≥1 goes to SEND. `start`=1 with `len`=0 goes to FIN. Otherwise stay in IDLE.
  - SEND: `down_valid`=1. A beat is accepted when valid and `down_ready` are both high at the rising edge.
  - GAP: `down_valid`=0 for exactly `gap` cycles, then SEND.
  - FIN: `done`=1 for one cycle, then IDLE.
- SEND transitions:
  - Accept of the last beat goes to FIN.
  - Accept of a non-last beat with `gap`=0 stays in SEND (back-to-back beats).
  - Accept of a non-last beat with `gap`>0 goes to GAP.
  - No accept stays in SEND.
- Data rules:
  - Beat i carries `down_data` = (`seed` + i) mod 2^DATA_W.
  - Index i is LEN_W bits wide and counts up to `len`-1.
  - While `down_valid`=1 and no accept occurs, `down_data` is held stable and valid is never withdrawn.
- `beat_cnt`:
  - Cleared to 0 on accepted `start`.
  - Increments on each accept.
  - Holds its final value after the packet, until the next start.
- `busy`=1 in SEND, GAP and FIN; `busy`=0 in IDLE.
- `start` is ignored while `busy`=1. No queuing.
- `down_ready` is ignored outside SEND.

## Timing
- Reset values: `down_valid`=0, `down_data`=0, `busy`=0, `done`=0, `beat_cnt`=0, state IDLE, gap counter 0.
- All outputs are registered. There is no combinational path from `down_ready` or `start` to any output.
- Start latency: `start` is sampled at edge T. Then `down_valid`=1, `down_data`=`seed` and `busy`=1 from T+1 on.
- Back-to-back (`gap`=0) with `down_ready` held at 1: one beat per cycle, so an N-beat packet occupies N consecutive valid cycles.
- Gap: an accept at edge T (non-last beat) gives valid=0 for cycles T+1..T+gap, and valid=1 with the next data at T+gap+1.
- Completion: the last accept at edge T gives valid=0 and `done`=1 at T+1, and `busy`=0 at T+2.
- `done` in a cycle implies `busy`=1 in that cycle.
- Minimum spacing: a `start` at the edge where `busy` has just fallen is accepted. The next valid follows one cycle later.
- `len`=0: `done` pulses in the cycle after start and `down_valid` never rises. `beat_cnt`=0.
- `len`=2^LEN_W−1 is the maximum packet. The counter does not overflow.
- Data wrap: `seed`=0xFE with 4 beats gives 0xFE, 0xFF, 0x00, 0x01.
- Reset asserted mid-packet: all outputs return to their reset values immediately (asynchronously), including dropping `down_valid`. This is the only permitted valid withdrawal. After release the block is in IDLE and the packet is abandoned.
- Simultaneous `start` and `down_ready` in IDLE: the start is taken and the ready is ignored.

## Test plan
- **Basic packet.** `len`=4, `seed`=0x10, `gap`=0, ready=1.
  - Data 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles starting at T+1.
  - `done` at T+5. `beat_cnt`=4.
- **Backpressure.** `len`=3, `seed`=0xA0, ready low on cycles 2 and 3 of the packet.
  - Valid stays 1 and data holds 0xA1 until ready returns.
  - No beat is skipped or duplicated. `done` follows the third accept.
- **Gap insertion.** `len`=3, `gap`=2, ready=1.
  - Valid pattern from T+1: 1,0,0,1,0,0,1.
  - `done` is high one cycle after the last 1.
- **Boundary values.**
  - `len`=0: `done` at T+1 with no valid.
  - `seed`=0xFE, `len`=4: data wraps to 0x00, 0x01.
  - `start` while `busy`: ignored, and `beat_cnt` is unaffected.
- **Reset mid-packet.** Assert `rst_n`=0 after 2 of 5 beats.
  - Valid, `busy` and `beat_cnt` are 0 immediately.
  - After release, a new `len`=1 start runs cleanly.
- **Random-ready soak.** Drive the block through the proxy chain with a random-ready sink for 1000 packets of random `len`, `seed` and `gap`.
  - The scoreboard sees the exact `seed`+i sequence per packet.
  - Exactly one `done` per packet.

Source files
------------

// File: rtl/rv_stream_source.sv
// Purpose: ready/valid packet generator; each start emits len beats carrying seed+i, with optional idle gaps.
// Latency: first beat is valid one cycle after start; done pulses one cycle after the final accept.
// Backpressure: down_valid and down_data are held while down_ready is low; valid is dropped only by reset.
module rv_stream_source #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8,
    parameter int GAP_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] seed,
    input  logic [GAP_W-1:0]  gap,
    output logic [DATA_W-1:0] down_data,
    output logic              down_valid,
    input  logic              down_ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  beat_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [LEN_W-1:0]  len_q;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic              start_acc;
    logic              accept;
    logic              last_beat;

    // start is only honoured in IDLE; ready is only meaningful while presenting a beat
    assign start_acc = (state_q == ST_IDLE) && start;
    assign accept    = (state_q == ST_SEND) && down_ready;
    // beat_cnt doubles as the index of the beat currently on the bus
    assign last_beat = (beat_cnt == (len_q - LEN_W'(1)));

    // State register plus registered status outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            down_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            down_valid <= (state_d == ST_SEND);
            busy       <= (state_d != ST_IDLE);
            done       <= (state_d == ST_FIN);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? ST_FIN : ST_SEND;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    if (last_beat) begin
                        state_d = ST_FIN;
                    end else if (gap_q != '0) begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                // counter was loaded with gap_q on the accept; leave on its final idle cycle
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d = ST_SEND;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command latch, beat counter, data pattern and gap countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            down_data <= '0;
            beat_cnt  <= '0;
        end else begin
            if (start_acc) begin
                len_q     <= len;
                gap_q     <= gap;
                down_data <= seed;
                beat_cnt  <= '0;
            end else if (accept) begin
                // data advances with the index, wrapping modulo 2^DATA_W
                beat_cnt  <= beat_cnt + LEN_W'(1);
                down_data <= down_data + DATA_W'(1);
                gap_cnt_q <= gap_q;
            end else if (state_q == ST_GAP) begin
                gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv_stream_source.sv
// Purpose: directed and random-ready checks of rv_stream_source against hand-computed values.
// Latency: inputs are driven 1ns after each rising edge and outputs are checked at that same point.
// Backpressure: down_ready is driven from directed tables and from $urandom in the soak loop.
module tb_rv_stream_source;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic [7:0] seed;
    logic [3:0] gap;
    logic [7:0] down_data;
    logic       down_valid;
    logic       down_ready;
    logic       busy;
    logic       done;
    logic [7:0] beat_cnt;

    int n_cmp;
    int n_err;

    rv_stream_source #(
        .DATA_W (8),
        .LEN_W  (8),
        .GAP_W  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .seed       (seed),
        .gap        (gap),
        .down_data  (down_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .busy       (busy),
        .done       (done),
        .beat_cnt   (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [7:0] l, input logic [7:0] s, input logic [3:0] g);
        start = 1'b1;
        len   = l;
        seed  = s;
        gap   = g;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [6:0] gap_pat;
        logic [7:0] pseed;
        logic [7:0] prev_dat;
        int         plen;
        int         idx;
        int         cyc;
        bit         got_done;
        bit         acc;
        bit         prev_vld;
        bit         prev_acc;

        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        len        = 8'd0;
        seed       = 8'd0;
        gap        = 4'd0;
        down_ready = 1'b0;

        // reset state
        #12;
        chk("rst_valid", down_valid, 0);
        chk("rst_data", down_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", beat_cnt, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // basic packet, ready already high while the start is taken
        down_ready = 1'b1;
        cmd(8'd4, 8'h10, 4'd0);
        for (int i = 0; i < 4; i++) begin
            chk("basic_valid", down_valid, 1);
            chk("basic_data", down_data, 8'h10 + i);
            chk("basic_busy", busy, 1);
            chk("basic_done_low", done, 0);
            tick();
        end
        chk("basic_done", done, 1);
        chk("basic_valid_end", down_valid, 0);
        chk("basic_busy_done", busy, 1);
        chk("basic_cnt", beat_cnt, 4);
        tick();
        chk("basic_idle_busy", busy, 0);
        chk("basic_idle_done", done, 0);
        chk("basic_cnt_hold", beat_cnt, 4);

        // backpressure: ready low on packet cycles 2 and 3
        cmd(8'd3, 8'hA0, 4'd0);
        chk("bp_d0", down_data, 8'hA0);
        tick();
        down_ready = 1'b0;
        chk("bp_v1", down_valid, 1);
        chk("bp_d1", down_data, 8'hA1);
        chk("bp_cnt1", beat_cnt, 1);
        tick();
        chk("bp_v2", down_valid, 1);
        chk("bp_d2", down_data, 8'hA1);
        tick();
        down_ready = 1'b1;
        chk("bp_v3", down_valid, 1);
        chk("bp_d3", down_data, 8'hA1);
        chk("bp_cnt3", beat_cnt, 1);
        tick();
        chk("bp_d4", down_data, 8'hA2);
        chk("bp_done_early", done, 0);
        tick();
        chk("bp_done", done, 1);
        chk("bp_cnt", beat_cnt, 3);
        tick();

        // gap insertion: valid 1,0,0,1,0,0,1 then done
        gap_pat = 7'b1001001;
        cmd(8'd3, 8'h30, 4'd2);
        for (int i = 0; i < 7; i++) begin
            chk("gap_valid", down_valid, gap_pat[i]);
            if (gap_pat[i]) chk("gap_data", down_data, 8'h30 + i / 3);
            tick();
        end
        chk("gap_done", done, 1);
        chk("gap_cnt", beat_cnt, 3);
        tick();

        // empty packet
        cmd(8'd0, 8'h55, 4'd0);
        chk("len0_done", done, 1);
        chk("len0_valid", down_valid, 0);
        chk("len0_busy", busy, 1);
        chk("len0_cnt", beat_cnt, 0);
        tick();
        chk("len0_idle", busy, 0);
        chk("len0_valid2", down_valid, 0);

        // data wrap
        cmd(8'd4, 8'hFE, 4'd0);
        chk("wrap_d0", down_data, 8'hFE);
        tick();
        chk("wrap_d1", down_data, 8'hFF);
        tick();
        chk("wrap_d2", down_data, 8'h00);
        tick();
        chk("wrap_d3", down_data, 8'h01);
        tick();
        chk("wrap_done", done, 1);
        tick();

        // start while busy is ignored
        cmd(8'd5, 8'h40, 4'd0);
        chk("ign_d0", down_data, 8'h40);
        tick();
        start = 1'b1;
        len   = 8'd1;
        seed  = 8'h99;
        chk("ign_d1", down_data, 8'h41);
        tick();
        start = 1'b0;
        chk("ign_d2", down_data, 8'h42);
        chk("ign_cnt2", beat_cnt, 2);
        tick();
        chk("ign_d3", down_data, 8'h43);
        tick();
        chk("ign_d4", down_data, 8'h44);
        tick();
        chk("ign_done", done, 1);
        chk("ign_cnt", beat_cnt, 5);
        tick();
        chk("ign_idle", busy, 0);

        // reset mid-packet; the start lands on the edge right after busy fell
        cmd(8'd5, 8'h50, 4'd0);
        tick();
        tick();
        chk("mid_d2", down_data, 8'h52);
        chk("mid_cnt2", beat_cnt, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", down_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", beat_cnt, 0);
        chk("mid_rst_data", down_data, 0);
        #4;
        rst_n = 1'b1;
        tick();
        chk("mid_post_valid", down_valid, 0);
        chk("mid_post_busy", busy, 0);
        cmd(8'd1, 8'h77, 4'd0);
        chk("mid_new_valid", down_valid, 1);
        chk("mid_new_data", down_data, 8'h77);
        tick();
        chk("mid_new_done", done, 1);
        chk("mid_new_cnt", beat_cnt, 1);
        tick();
        chk("mid_new_idle", busy, 0);

        // random-ready soak with a scoreboard
        for (int p = 0; p < 1000; p++) begin
            plen  = $urandom_range(0, 12);
            pseed = 8'($urandom_range(0, 255));
            down_ready = 1'($urandom_range(0, 1));
            cmd(8'(plen), pseed, 4'($urandom_range(0, 3)));
            idx      = 0;
            cyc      = 0;
            got_done = 1'b0;
            prev_vld = 1'b0;
            prev_acc = 1'b0;
            prev_dat = 8'd0;
            while (!got_done && cyc < 400) begin
                if (prev_vld && !prev_acc) begin
                    chk("soak_hold_valid", down_valid, 1);
                    chk("soak_hold_data", down_data, prev_dat);
                end
                if (down_valid) begin
                    chk("soak_data", down_data, 8'(pseed + idx));
                    chk("soak_in_range", (idx < plen), 1);
                end
                if (done) begin
                    got_done = 1'b1;
                    chk("soak_done_busy", busy, 1);
                    chk("soak_beats", idx, plen);
                    chk("soak_cnt", beat_cnt, plen);
                end
                acc      = down_valid && down_ready;
                prev_vld = down_valid;
                prev_acc = acc;
                prev_dat = down_data;
                tick();
                if (acc) idx++;
                down_ready = 1'($urandom_range(0, 1));
                cyc++;
            end
            if (!got_done) begin
                chk("soak_timeout", 0, 1);
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
                tick();
            end else begin
                chk("soak_single_done", done, 0);
                chk("soak_idle", busy, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
